atm_controller_mc: RTL and testbench

Parametrised successor to the single-account ATM state machine. It serves NUM_ACCTS accounts from an internal balance table and sequences card insertion, language select, PIN entry, service dispatch, deposit, withdraw, balance query and the "another service" prompt. It adds per-state inactivity timeouts, PIN retry with per-account lockout, and overflow/insufficient-funds checks. Status is reported on registered outputs rather than simulation messages. It sits between the keypad/card front end and the display/cash-dispense logic.

---
 rtl/atm_controller_mc.sv | 259 +++++++++++++++++++++++++
 tb/tb_atm_controller_mc.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_controller_mc.sv
// Multi-account ATM session controller: card, language, PIN, service dispatch and balance table.
// Per-state inactivity timeout, PIN retry with per-account lockout, and registered status pulses.
module atm_controller_mc #(
  parameter int unsigned NUM_ACCTS = 4,
  parameter int unsigned ACCT_W    = 2,
  parameter int unsigned BAL_W     = 8,
  parameter int unsigned PIN_W     = 4,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned INIT_BAL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 card_valid,
  input  logic [ACCT_W-1:0]    card_id,
  input  logic                 lang_valid,
  input  logic [1:0]           lang,
  input  logic                 pin_valid,
  input  logic [PIN_W-1:0]     pin,
  input  logic [PIN_W-1:0]     pin_ref,
  input  logic                 svc_valid,
  input  logic [2:0]           service,
  input  logic [BAL_W-1:0]     amount,
  input  logic                 another_valid,
  input  logic                 another,
  output logic [3:0]           state_out,
  output logic [1:0]           lang_sel,
  output logic [BAL_W-1:0]     balance_out,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic                 card_eject,
  output logic [NUM_ACCTS-1:0] locked
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] ErrTimeout = 3'd1;
  localparam logic [2:0] ErrBadPin  = 3'd2;
  localparam logic [2:0] ErrLocked  = 3'd3;
  localparam logic [2:0] ErrZero    = 3'd4;
  localparam logic [2:0] ErrOvf     = 3'd5;
  localparam logic [2:0] ErrFunds   = 3'd6;
  localparam logic [2:0] ErrSvc     = 3'd7;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StLang     = 4'd1,
    StPin      = 4'd2,
    StService  = 4'd3,
    StDeposit  = 4'd4,
    StWithdraw = 4'd5,
    StBalance  = 4'd6,
    StAnother  = 4'd7,
    StEject    = 4'd8
  } state_e;

  state_e                         state_q, state_d;
  logic [ACCT_W-1:0]              acct_q, acct_d;
  logic [1:0]                     lang_q, lang_d;
  logic [BAL_W-1:0]               amt_q, amt_d;
  logic [2:0]                     try_q, try_d;
  logic [TmoW-1:0]                tmo_q, tmo_d;
  logic [NUM_ACCTS-1:0][BAL_W-1:0] bal_q, bal_d;
  logic [NUM_ACCTS-1:0]           locked_q, locked_d;
  logic [BAL_W-1:0]               bal_out_q, bal_out_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic [2:0]                     code_q, code_d;
  logic                           eject_q, eject_d;

  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W:0]   sum;
  logic             tmo_hit;

  always_comb begin
    state_d   = state_q;
    acct_d    = acct_q;
    lang_d    = lang_q;
    amt_d     = amt_q;
    try_d     = try_q;
    tmo_d     = '0;
    bal_d     = bal_q;
    locked_d  = locked_q;
    bal_out_d = bal_out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    eject_d   = 1'b0;
    cur_bal   = bal_q[acct_q];
    sum       = {1'b0, cur_bal} + {1'b0, amt_q};
    tmo_hit   = (tmo_q == TmoW'(TIMEOUT - 1));

    unique case (state_q)
      StIdle: begin
        if (card_valid) begin
          acct_d = card_id;
          if (locked_q[card_id]) begin
            err_d   = 1'b1;
            code_d  = ErrLocked;
            state_d = StEject;
          end else begin
            state_d = StLang;
          end
        end
      end
      StLang: begin
        if (lang_valid && (lang == 2'b01 || lang == 2'b10)) begin
          lang_d  = lang;
          state_d = StPin;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = ErrTimeout;
          state_d = StEject;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StPin: begin
        if (pin_valid) begin
          if (pin == pin_ref) begin
            try_d   = '0;
            state_d = StService;
          end else if (32'(try_q) + 32'd1 >= MAX_TRIES) begin
            locked_d[acct_q] = 1'b1;
            err_d   = 1'b1;
            code_d  = ErrLocked;
            state_d = StEject;
          end else begin
            try_d  = try_q + 3'd1;
            err_d  = 1'b1;
            code_d = ErrBadPin;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = ErrTimeout;
          state_d = StEject;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StService: begin
        if (svc_valid) begin
          amt_d = amount;
          case (service)
            3'b001:  state_d = StDeposit;
            3'b010:  state_d = StWithdraw;
            3'b011:  state_d = StBalance;
            default: begin
              err_d  = 1'b1;
              code_d = ErrSvc;
            end
          endcase
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = ErrTimeout;
          state_d = StEject;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDeposit: begin
        bal_out_d = cur_bal;
        if (amt_q == '0) begin
          err_d  = 1'b1;
          code_d = ErrZero;
        end else if (sum[BAL_W]) begin
          err_d  = 1'b1;
          code_d = ErrOvf;
        end else begin
          bal_d[acct_q] = sum[BAL_W-1:0];
          bal_out_d     = sum[BAL_W-1:0];
          done_d        = 1'b1;
        end
        state_d = StAnother;
      end
      StWithdraw: begin
        bal_out_d = cur_bal;
        if (amt_q == '0) begin
          err_d  = 1'b1;
          code_d = ErrZero;
        end else if (amt_q > cur_bal) begin
          err_d  = 1'b1;
          code_d = ErrFunds;
        end else begin
          bal_d[acct_q] = cur_bal - amt_q;
          bal_out_d     = cur_bal - amt_q;
          done_d        = 1'b1;
        end
        state_d = StAnother;
      end
      StBalance: begin
        bal_out_d = cur_bal;
        done_d    = 1'b1;
        state_d   = StAnother;
      end
      StAnother: begin
        if (another_valid) begin
          state_d = another ? StService : StEject;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = ErrTimeout;
          state_d = StEject;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StEject: begin
        lang_d  = 2'b00;
        try_d   = '0;
        eject_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acct_q    <= '0;
      lang_q    <= '0;
      amt_q     <= '0;
      try_q     <= '0;
      tmo_q     <= '0;
      bal_q     <= {NUM_ACCTS{BAL_W'(INIT_BAL)}};
      locked_q  <= '0;
      bal_out_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      eject_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acct_q    <= acct_d;
      lang_q    <= lang_d;
      amt_q     <= amt_d;
      try_q     <= try_d;
      tmo_q     <= tmo_d;
      bal_q     <= bal_d;
      locked_q  <= locked_d;
      bal_out_q <= bal_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      eject_q   <= eject_d;
    end
  end

  assign state_out   = state_q;
  assign lang_sel    = lang_q;
  assign balance_out = bal_out_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign card_eject  = eject_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_atm_controller_mc.sv
// Bench for atm_controller_mc: directed session table, hand-written corner sequences and
// randomized sessions checked against an account-level model (balances, locks, error codes).
module tb_atm_controller_mc;

  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned MAX_TRIES = 3;
  localparam int unsigned MAX_BAL   = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       card_valid = 1'b0;
  logic [1:0] card_id = '0;
  logic       lang_valid = 1'b0;
  logic [1:0] lang = '0;
  logic       pin_valid = 1'b0;
  logic [3:0] pin = '0;
  logic [3:0] pin_ref = '0;
  logic       svc_valid = 1'b0;
  logic [2:0] service = '0;
  logic [7:0] amount = '0;
  logic       another_valid = 1'b0;
  logic       another = 1'b0;
  logic [3:0] state_out;
  logic [1:0] lang_sel;
  logic [7:0] balance_out;
  logic       done;
  logic       err;
  logic [2:0] err_code;
  logic       card_eject;
  logic [3:0] locked;

  atm_controller_mc #(
    .NUM_ACCTS(4), .ACCT_W(2), .BAL_W(8), .PIN_W(4),
    .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT), .INIT_BAL(0)
  ) dut (
    .clk(clk), .rst(rst),
    .card_valid(card_valid), .card_id(card_id),
    .lang_valid(lang_valid), .lang(lang),
    .pin_valid(pin_valid), .pin(pin), .pin_ref(pin_ref),
    .svc_valid(svc_valid), .service(service), .amount(amount),
    .another_valid(another_valid), .another(another),
    .state_out(state_out), .lang_sel(lang_sel), .balance_out(balance_out),
    .done(done), .err(err), .err_code(err_code), .card_eject(card_eject),
    .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Account-level model
  int         m_bal[4];
  logic [3:0] m_lock;
  int         m_code;
  int         m_acct;
  int         m_tries;

  typedef struct {
    int card;
    int svc;
    int amt;
    int exp_code;  // 0 means success (done expected)
    int exp_bal;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done || err) begin
      checks++;
      if (done && err) begin
        errors++;
        $display("FAIL done_err_overlap: done=%0d err=%0d expected not both", done, err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    card_valid = 1'b0;
    lang_valid = 1'b0;
    pin_valid = 1'b0;
    svc_valid = 1'b0;
    another_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bal[i] = 0;
    m_lock = '0;
    m_code = 0;
    m_tries = 0;
  endtask

  task automatic model_svc(input int acct, input int svc, input int amt,
                           output int ecode, output int ebal);
    ecode = 0;
    if (svc == 1) begin
      if (amt == 0) ecode = 4;
      else if (m_bal[acct] + amt > MAX_BAL) ecode = 5;
      else m_bal[acct] = m_bal[acct] + amt;
    end else if (svc == 2) begin
      if (amt == 0) ecode = 4;
      else if (amt > m_bal[acct]) ecode = 6;
      else m_bal[acct] = m_bal[acct] - amt;
    end
    ebal = m_bal[acct];
  endtask

  // Idle cycles in a waiting state with strobes of other states as noise.
  task automatic gap(input int n, input int own);
    for (int i = 0; i < n; i++) begin
      card_valid = 1'($urandom_range(0, 1));
      card_id = 2'($urandom_range(0, 3));
      if (own != 1) begin lang_valid = 1'($urandom_range(0, 1)); lang = 2'b10; end
      if (own != 2) pin_valid = 1'($urandom_range(0, 1));
      if (own != 3) begin svc_valid = 1'($urandom_range(0, 1)); service = 3'b011; end
      if (own != 7) begin another_valid = 1'($urandom_range(0, 1)); another = 1'b1; end
      step();
      idle_in();
      chk("gap_state", int'(state_out), own);
      chk("gap_err", int'(err), 0);
    end
  endtask

  task automatic eject_step();
    step();
    chk("eject_state", int'(state_out), 0);
    chk("eject_pulse", int'(card_eject), 1);
    chk("eject_lang", int'(lang_sel), 0);
    chk("eject_locked", int'(locked), int'(m_lock));
    chk("eject_code", int'(err_code), m_code);
  endtask

  task automatic insert(input int card, output bit acc);
    card_valid = 1'b1;
    card_id = 2'(card);
    step();
    idle_in();
    m_acct = card;
    m_tries = 0;
    if (m_lock[card]) begin
      m_code = 3;
      chk("locked_card_state", int'(state_out), 8);
      chk("locked_card_err", int'(err), 1);
      chk("locked_card_code", int'(err_code), 3);
      eject_step();
      acc = 1'b0;
    end else begin
      chk("card_state", int'(state_out), 1);
      acc = 1'b1;
    end
  endtask

  task automatic choose_lang(input int l);
    lang_valid = 1'b1;
    lang = 2'(l);
    step();
    idle_in();
    chk("lang_state", int'(state_out), 2);
    chk("lang_sel", int'(lang_sel), l);
  endtask

  task automatic enter_pin(input bit ok, output int st);
    pin_ref = 4'(m_acct * 5 + 3);
    pin = ok ? pin_ref : (pin_ref ^ 4'($urandom_range(1, 15)));
    pin_valid = 1'b1;
    step();
    idle_in();
    if (ok) begin
      m_tries = 0;
      chk("pin_ok_state", int'(state_out), 3);
      chk("pin_ok_err", int'(err), 0);
      st = 0;
    end else begin
      m_tries++;
      if (m_tries >= int'(MAX_TRIES)) begin
        m_lock[m_acct] = 1'b1;
        m_code = 3;
        chk("pin_lock_state", int'(state_out), 8);
        chk("pin_lock_err", int'(err), 1);
        chk("pin_lock_code", int'(err_code), 3);
        chk("pin_lock_vec", int'(locked), int'(m_lock));
        st = 2;
      end else begin
        m_code = 2;
        chk("pin_bad_state", int'(state_out), 2);
        chk("pin_bad_err", int'(err), 1);
        chk("pin_bad_code", int'(err_code), 2);
        st = 1;
      end
    end
  endtask

  task automatic do_svc(input int svc, input int amt, input int ecode, input int ebal);
    svc_valid = 1'b1;
    service = 3'(svc);
    amount = 8'(amt);
    step();
    idle_in();
    chk("svc_state", int'(state_out), 3 + svc);
    step();
    chk("op_state", int'(state_out), 7);
    chk("op_done", int'(done), (ecode == 0) ? 1 : 0);
    chk("op_err", int'(err), (ecode != 0) ? 1 : 0);
    if (ecode != 0) m_code = ecode;
    chk("op_code", int'(err_code), m_code);
    chk("op_bal", int'(balance_out), ebal);
  endtask

  task automatic bad_svc(input int svc);
    svc_valid = 1'b1;
    service = 3'(svc);
    step();
    idle_in();
    m_code = 7;
    chk("badsvc_state", int'(state_out), 3);
    chk("badsvc_err", int'(err), 1);
    chk("badsvc_code", int'(err_code), 7);
  endtask

  task automatic answer(input bit a);
    another_valid = 1'b1;
    another = a;
    step();
    idle_in();
    chk("answer_state", int'(state_out), a ? 3 : 8);
  endtask

  task automatic timeout_in(input int own);
    gap(TIMEOUT - 1, own);
    step();
    m_code = 1;
    chk("tmo_state", int'(state_out), 8);
    chk("tmo_err", int'(err), 1);
    chk("tmo_code", int'(err_code), 1);
    eject_step();
  endtask

  initial begin
    vec_t tbl[15];
    bit   acc;
    int   st, ec, eb, card, svc, amt, r, nsvc;

    tbl[0]  = '{2, 1, 25,  0, 25};
    tbl[1]  = '{1, 1, 250, 0, 250};
    tbl[2]  = '{1, 1, 10,  5, 250};
    tbl[3]  = '{1, 2, 250, 0, 0};
    tbl[4]  = '{1, 2, 1,   6, 0};
    tbl[5]  = '{0, 1, 5,   0, 5};
    tbl[6]  = '{1, 1, 7,   0, 7};
    tbl[7]  = '{0, 3, 0,   0, 5};
    tbl[8]  = '{1, 3, 0,   0, 7};
    tbl[9]  = '{2, 1, 0,   4, 25};
    tbl[10] = '{2, 2, 0,   4, 25};
    tbl[11] = '{3, 2, 1,   6, 0};
    tbl[12] = '{2, 2, 25,  0, 0};
    tbl[13] = '{3, 1, 255, 0, 255};
    tbl[14] = '{3, 1, 1,   5, 255};

    model_reset();
    idle_in();
    step();
    step();
    rst = 1'b0;
    chk("rst_state", int'(state_out), 0);
    chk("rst_lang", int'(lang_sel), 0);
    chk("rst_bal", int'(balance_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_eject", int'(card_eject), 0);
    chk("rst_locked", int'(locked), 0);

    // Directed one-service sessions
    for (int i = 0; i < 15; i++) begin
      insert(tbl[i].card, acc);
      choose_lang(1);
      enter_pin(1'b1, st);
      model_svc(tbl[i].card, tbl[i].svc, tbl[i].amt, ec, eb);
      do_svc(tbl[i].svc, tbl[i].amt, tbl[i].exp_code, tbl[i].exp_bal);
      answer(1'b0);
      eject_step();
    end

    // Lockout on card 3, then immediate rejection on reinsertion
    insert(3, acc);
    choose_lang(2);
    for (int i = 0; i < 3; i++) enter_pin(1'b0, st);
    chk("lock3_status", st, 2);
    eject_step();
    insert(3, acc);
    chk("lock3_reject", int'(acc), 0);

    // Timeout in LANG; then a strobe on the last tolerated cycle wins; then PIN timeout
    insert(0, acc);
    timeout_in(1);
    insert(0, acc);
    gap(TIMEOUT - 1, 1);
    choose_lang(1);
    timeout_in(2);

    // Invalid service, another=1 loop, ANOTHER timeout
    insert(0, acc);
    choose_lang(2);
    enter_pin(1'b1, st);
    bad_svc(5);
    model_svc(0, 3, 0, ec, eb);
    do_svc(3, 0, ec, eb);
    answer(1'b1);
    model_svc(0, 1, 3, ec, eb);
    do_svc(1, 3, ec, eb);
    timeout_in(7);

    // Reset while in WITHDRAW
    insert(1, acc);
    choose_lang(1);
    enter_pin(1'b1, st);
    svc_valid = 1'b1;
    service = 3'b010;
    amount = 8'd3;
    step();
    idle_in();
    chk("wd_state", int'(state_out), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("mid_rst_state", int'(state_out), 0);
    chk("mid_rst_lang", int'(lang_sel), 0);
    chk("mid_rst_bal", int'(balance_out), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_code", int'(err_code), 0);
    chk("mid_rst_locked", int'(locked), 0);
    for (int c = 1; c < 4; c += 2) begin
      insert(c, acc);
      chk("post_rst_accept", int'(acc), 1);
      choose_lang(1);
      enter_pin(1'b1, st);
      model_svc(c, 3, 0, ec, eb);
      do_svc(3, 0, ec, eb);
      answer(1'b0);
      eject_step();
    end

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      card = $urandom_range(0, 3);
      insert(card, acc);
      if (!acc) continue;
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) begin
        gap($urandom_range(0, 2), 1);
        lang_valid = 1'b1;
        lang = $urandom_range(0, 1) ? 2'b00 : 2'b11;
        step();
        idle_in();
        chk("badlang_state", int'(state_out), 1);
        chk("badlang_sel", int'(lang_sel), 0);
      end
      gap($urandom_range(0, 3), 1);
      choose_lang($urandom_range(0, 1) ? 1 : 2);
      st = 1;
      while (st == 1) begin
        gap($urandom_range(0, 3), 2);
        enter_pin($urandom_range(0, 2) != 0, st);
      end
      if (st == 2) begin
        eject_step();
        continue;
      end
      nsvc = $urandom_range(1, 3);
      for (int k = 0; k < nsvc; k++) begin
        gap($urandom_range(0, 3), 3);
        r = $urandom_range(0, 9);
        svc = (r < 4) ? 1 : (r < 8) ? 2 : (r == 8) ? 3 : 0;
        if (svc == 0) begin
          r = $urandom_range(4, 8);
          bad_svc((r == 8) ? 0 : r);
          svc = 3;
        end
        r = $urandom_range(0, 3);
        amt = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(1, 20)) :
              (r == 2) ? int'($urandom_range(0, 255)) :
              (svc == 2) ? m_bal[card] : int'(MAX_BAL) - m_bal[card];
        model_svc(card, svc, amt, ec, eb);
        do_svc(svc, amt, ec, eb);
        if ($urandom_range(0, 9) == 0) begin
          timeout_in(7);
          break;
        end
        gap($urandom_range(0, 3), 7);
        answer(k != nsvc - 1);
        if (k == nsvc - 1) eject_step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
